// File: rtl/accumulator_mc_if.sv
// Board-side bundle for accumulator_mc: button, operand and control inputs,
// plus the snapshot, overflow and done outputs.
interface accumulator_mc_if #(
    parameter int Word_Length = 8,
    parameter int CHANNELS    = 4
);
    localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    logic                   n_enable;
    logic                   sub;
    logic                   clear;
    logic [CW-1:0]          ch_sel;
    logic                   read;
    logic [Word_Length-1:0] Data_Input;
    logic [Word_Length-1:0] Data_Output;
    logic [CW-1:0]          out_ch;
    logic [CHANNELS-1:0]    ovf;
    logic                   acc_done;

    modport master (
        output n_enable, sub, clear, ch_sel, read, Data_Input,
        input  Data_Output, out_ch, ovf, acc_done
    );

    modport slave (
        input  n_enable, sub, clear, ch_sel, read, Data_Input,
        output Data_Output, out_ch, ovf, acc_done
    );
endinterface

// File: rtl/accumulator_mc.sv
// Multi-channel add/subtract accumulator with sticky overflow flags,
// driven by a synchronized, debounced, one-shot active-low button.
module accumulator_mc #(
    parameter int Word_Length     = 8,
    parameter int CHANNELS        = 4,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter bit SATURATE        = 1'b1
) (
    input logic             clk,
    input logic             n_rst,
    accumulator_mc_if.slave bus
);
    localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int NW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [NW-1:0] CNT_MAX = NW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        ARM_PRESS,
        PRESSED,
        ARM_RELEASE
    } state_t;

    state_t                 state;
    state_t                 state_nx;
    logic [NW-1:0]          cnt;
    logic [NW-1:0]          cnt_nx;
    logic                   sync1;
    logic                   sync2;
    logic                   one_shot;

    logic [Word_Length-1:0] acc [CHANNELS];
    logic [CHANNELS-1:0]    ovf_q;
    logic [Word_Length-1:0] dout_q;
    logic [CW-1:0]          och_q;
    logic                   done_q;

    logic [Word_Length-1:0] cur;
    logic                   sel_ok;
    logic [Word_Length:0]   sum;
    logic [Word_Length:0]   diff;
    logic [Word_Length-1:0] res;
    logic                   flow;

    // Both flops idle at 1 so reset looks like a released button.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
        end else begin
            sync1 <= bus.n_enable;
            sync2 <= sync1;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        one_shot = 1'b0;
        unique case (state)
            IDLE: begin
                if (!sync2) begin
                    state_nx = ARM_PRESS;
                    cnt_nx   = '0;
                end
            end
            ARM_PRESS: begin
                if (sync2) begin
                    state_nx = IDLE;
                    cnt_nx   = '0;
                end else if (cnt == CNT_MAX) begin
                    state_nx = PRESSED;
                    cnt_nx   = '0;
                    one_shot = 1'b1;
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            PRESSED: begin
                if (sync2) begin
                    state_nx = ARM_RELEASE;
                    cnt_nx   = '0;
                end
            end
            ARM_RELEASE: begin
                if (!sync2) begin
                    state_nx = PRESSED;
                    cnt_nx   = '0;
                end else if (cnt == CNT_MAX) begin
                    state_nx = IDLE;
                    cnt_nx   = '0;
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            default: begin
                state_nx = IDLE;
                cnt_nx   = '0;
            end
        endcase
    end

    // Out-of-range ch_sel selects nothing and reads as zero.
    always_comb begin
        cur    = '0;
        sel_ok = 1'b0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (bus.ch_sel == CW'(i)) begin
                cur    = acc[i];
                sel_ok = 1'b1;
            end
        end
    end

    always_comb begin
        sum  = {1'b0, cur} + {1'b0, bus.Data_Input};
        diff = {1'b0, cur} - {1'b0, bus.Data_Input};
        if (bus.sub) begin
            flow = diff[Word_Length];
            res  = (flow && SATURATE) ? '0 : diff[Word_Length-1:0];
        end else begin
            flow = sum[Word_Length];
            res  = (flow && SATURATE) ? '1 : sum[Word_Length-1:0];
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            for (int i = 0; i < CHANNELS; i++) begin
                acc[i] <= '0;
            end
            ovf_q <= '0;
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (bus.ch_sel == CW'(i)) begin
                    if (bus.clear) begin
                        acc[i]   <= '0;
                        ovf_q[i] <= 1'b0;
                    end else if (one_shot) begin
                        acc[i] <= res;
                        if (flow) begin
                            ovf_q[i] <= 1'b1;
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            dout_q <= '0;
            och_q  <= '0;
            done_q <= 1'b0;
        end else begin
            if (bus.read) begin
                dout_q <= cur;
                och_q  <= bus.ch_sel;
            end
            done_q <= one_shot && sel_ok && !bus.clear;
        end
    end

    assign bus.Data_Output = dout_q;
    assign bus.out_ch      = och_q;
    assign bus.ovf         = ovf_q;
    assign bus.acc_done    = done_q;
endmodule

// File: tb/tb_accumulator_mc.sv
// Scoreboard bench for accumulator_mc: a saturating and a wrapping instance
// share one stimulus stream and are checked against a reference model.
module tb_accumulator_mc;
    localparam int W = 8;
    localparam int C = 4;
    localparam int D = 4;

    typedef struct {
        logic [W-1:0] s;
        logic [W-1:0] w;
        logic [1:0]   ch;
    } exp_t;

    logic clk;
    logic n_rst;
    int   errors;
    int   checks;
    int   done_s;
    int   done_w;
    int   ms [C];
    int   mw [C];
    bit [C-1:0] os;
    bit [C-1:0] ow;
    exp_t sb [$];

    accumulator_mc_if #(.Word_Length(W), .CHANNELS(C)) bs ();
    accumulator_mc_if #(.Word_Length(W), .CHANNELS(C)) bw ();

    assign bw.n_enable   = bs.n_enable;
    assign bw.sub        = bs.sub;
    assign bw.clear      = bs.clear;
    assign bw.ch_sel     = bs.ch_sel;
    assign bw.read       = bs.read;
    assign bw.Data_Input = bs.Data_Input;

    accumulator_mc #(
        .Word_Length(W), .CHANNELS(C),
        .DEBOUNCE_CYCLES(D), .SATURATE(1'b1)
    ) dut_sat (
        .clk(clk), .n_rst(n_rst), .bus(bs)
    );

    accumulator_mc #(
        .Word_Length(W), .CHANNELS(C),
        .DEBOUNCE_CYCLES(D), .SATURATE(1'b0)
    ) dut_wrap (
        .clk(clk), .n_rst(n_rst), .bus(bw)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bs.acc_done === 1'b1) done_s++;
        if (bw.acc_done === 1'b1) done_w++;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic void model_reset();
        for (int i = 0; i < C; i++) begin
            ms[i] = 0;
            mw[i] = 0;
        end
        os = '0;
        ow = '0;
    endfunction

    function automatic void model_acc(input int ch, input bit s, input int d);
        int r;
        r = s ? ms[ch] - d : ms[ch] + d;
        if (r > 255) begin
            os[ch] = 1'b1;
            r = 255;
        end else if (r < 0) begin
            os[ch] = 1'b1;
            r = 0;
        end
        ms[ch] = r;
        r = s ? mw[ch] - d : mw[ch] + d;
        if (r > 255 || r < 0) ow[ch] = 1'b1;
        mw[ch] = r & 255;
    endfunction

    task automatic push_exp(input int ch);
        exp_t e;
        e.s  = W'(ms[ch]);
        e.w  = W'(mw[ch]);
        e.ch = 2'(ch);
        sb.push_back(e);
    endtask

    task automatic sb_check();
        exp_t e;
        if (sb.size() == 0) begin
            check("sb_empty", 1, 0);
        end else begin
            e = sb.pop_front();
            check("rd_sat", bs.Data_Output, e.s);
            check("rd_wrap", bw.Data_Output, e.w);
            check("rd_ch", bs.out_ch, e.ch);
        end
    endtask

    task automatic rd(input int ch);
        bs.ch_sel = 2'(ch);
        bs.read   = 1'b1;
        push_exp(ch);
        tick(1);
        bs.read = 1'b0;
        sb_check();
    endtask

    task automatic chk_ovf(input string tag);
        check({tag, "_sat"}, bs.ovf, os);
        check({tag, "_wrap"}, bw.ovf, ow);
    endtask

    task automatic press(input int ch, input bit s, input int d, input int hold);
        int n0s;
        int n0w;
        n0s = done_s;
        n0w = done_w;
        bs.ch_sel     = 2'(ch);
        bs.sub        = s;
        bs.Data_Input = W'(d);
        bs.n_enable   = 1'b0;
        tick(hold);
        bs.n_enable = 1'b1;
        tick(10);
        model_acc(ch, s, d);
        check("press_cnt_sat", done_s - n0s, 1);
        check("press_cnt_wrap", done_w - n0w, 1);
    endtask

    initial begin
        int n0;
        errors = 0;
        checks = 0;
        done_s = 0;
        done_w = 0;
        model_reset();
        n_rst         = 1'b0;
        bs.n_enable   = 1'b1;
        bs.sub        = 1'b0;
        bs.clear      = 1'b0;
        bs.ch_sel     = '0;
        bs.read       = 1'b0;
        bs.Data_Input = '0;
        tick(3);
        check("rst_dout", bs.Data_Output, 0);
        check("rst_och", bs.out_ch, 0);
        check("rst_done", bs.acc_done, 0);
        chk_ovf("rst_ovf");
        n_rst = 1'b1;
        tick(3);

        // Single press with exact latency.
        n0 = done_s;
        bs.ch_sel     = 2'd1;
        bs.Data_Input = 8'd5;
        bs.sub        = 1'b0;
        bs.n_enable   = 1'b0;
        tick(D + 2);
        check("done_early", bs.acc_done, 0);
        tick(1);
        check("done_lat", bs.acc_done, 1);
        tick(20 - D - 3);
        bs.n_enable = 1'b1;
        tick(10);
        model_acc(1, 1'b0, 5);
        check("single_cnt", done_s - n0, 1);
        for (int i = 0; i < C; i++) rd(i);

        // Bounce shorter than the debounce window.
        n0 = done_s;
        bs.n_enable = 1'b0;
        tick(2);
        bs.n_enable = 1'b1;
        tick(1);
        bs.n_enable = 1'b0;
        tick(2);
        bs.n_enable = 1'b1;
        tick(10);
        check("bounce_none", done_s - n0, 0);
        press(1, 1'b0, 3, 10);
        rd(1);

        // Saturate vs wrap.
        press(0, 1'b0, 250, 10);
        press(0, 1'b0, 10, 10);
        press(1, 1'b1, 5, 10);
        press(1, 1'b1, 7, 10);
        rd(0);
        rd(1);
        chk_ovf("ovf_flow");

        // Clear beats accumulate; read sees the old value.
        press(2, 1'b1, 1, 10);
        press(2, 1'b0, 9, 10);
        rd(2);
        chk_ovf("ovf_ch2");
        n0 = done_s;
        bs.ch_sel     = 2'd2;
        bs.sub        = 1'b0;
        bs.Data_Input = 8'd1;
        bs.n_enable   = 1'b0;
        tick(D + 2);
        bs.clear = 1'b1;
        bs.read  = 1'b1;
        push_exp(2);
        tick(1);
        bs.clear = 1'b0;
        bs.read  = 1'b0;
        sb_check();
        ms[2] = 0;
        mw[2] = 0;
        os[2] = 1'b0;
        ow[2] = 1'b0;
        tick(3);
        bs.n_enable = 1'b1;
        tick(10);
        check("clr_nodone", done_s - n0, 0);
        chk_ovf("clr_ovf");
        rd(2);

        // Reset while in ARM_PRESS.
        rd(0);
        bs.ch_sel     = 2'd3;
        bs.Data_Input = 8'd2;
        bs.sub        = 1'b0;
        bs.n_enable   = 1'b0;
        tick(4);
        n_rst = 1'b0;
        #1;
        check("mid_rst_dout_sat", bs.Data_Output, 0);
        check("mid_rst_dout_wrap", bw.Data_Output, 0);
        check("mid_rst_done", bs.acc_done, 0);
        model_reset();
        chk_ovf("mid_rst_ovf");
        tick(2);
        n_rst = 1'b1;
        n0 = done_s;
        tick(D + 2);
        check("rst_no_early", done_s - n0, 0);
        tick(4);
        check("rst_one", done_s - n0, 1);
        bs.n_enable = 1'b1;
        tick(10);
        model_acc(3, 1'b0, 2);
        rd(3);
        rd(0);

        // Long hold gives one update; re-press gives another.
        press(3, 1'b0, 1, 100);
        rd(3);
        press(3, 1'b0, 1, 10);
        rd(3);
        chk_ovf("final_ovf");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/accumulator_mc.md
# accumulator_mc

Multi-channel successor to the single-channel button-driven accumulator. It holds CHANNELS independent accumulators of Word_Length bits, selectable add/subtract, and a per-channel sticky overflow flag. It has an integrated synchronizer/debouncer/one-shot on the active-low enable button. A snapshot output register is loaded on `read`. The block sits between the board switches/buttons and the display/output logic.

## Interface
- Word_Length, 8, accumulator and data width (unsigned)
- CHANNELS, 4, number of accumulators, ≥2
- DEBOUNCE_CYCLES, 16, consecutive stable synchronized cycles needed to accept a press or release, ≥1
- SATURATE, 1, 1 = clamp on overflow/underflow, 0 = modulo wrap
- clk, in, 1, system clock, all logic rising-edge
- n_rst, in, 1, asynchronous active-low reset
- n_enable, in, 1, asynchronous active-low button; one accepted press = one accumulate
- sub, in, 1, 0 = add Data_Input, 1 = subtract Data_Input
- clear, in, 1, synchronous clear of channel ch_sel (accumulator and its ovf bit)
- ch_sel, in, clog2(CHANNELS), target channel for accumulate, clear and read
- read, in, 1, load snapshot of channel ch_sel into Data_Output
- Data_Input, in, Word_Length, operand
- Data_Output, out, Word_Length, snapshot value
- out_ch, out, clog2(CHANNELS), channel index of current snapshot
- ovf, out, CHANNELS, sticky overflow/underflow flag per channel
- acc_done, out, 1, one-cycle pulse after each accumulator update

## Operation
- The n_enable input passes through a two-flop synchronizer. Both flops reset to 1 (released).
- Debounce FSM states: IDLE, ARM_PRESS, PRESSED, ARM_RELEASE. A counter runs 0..DEBOUNCE_CYCLES-1.
  - IDLE: when the synced level is 0, go to ARM_PRESS with the counter cleared.
  - ARM_PRESS: the counter increments while the level stays 0. If the level returns to 1, go to IDLE. When the counter reaches DEBOUNCE_CYCLES-1 with the level still 0, go to PRESSED and assert one_shot for exactly that one cycle.
  - PRESSED: when the level is 1, go to ARM_RELEASE with the counter cleared.
  - ARM_RELEASE: the counter increments while the level stays 1. If the level returns to 0, go back to PRESSED with no new pulse. When the counter reaches DEBOUNCE_CYCLES-1, go to IDLE.
- Accumulate: in a one_shot cycle, acc[ch_sel] ← acc[ch_sel] ± Data_Input, using ch_sel, sub and Data_Input sampled in that cycle.
- Arithmetic uses a Word_Length+1 bit intermediate.
  - Add with carry out: ovf[ch] ← 1. The result is all-ones if SATURATE, otherwise the low Word_Length bits.
  - Subtract with borrow: ovf[ch] ← 1. The result is 0 if SATURATE, otherwise the low Word_Length bits (two's-complement wrap).
  - Without carry/borrow, ovf is unchanged (sticky).
- clear has priority over one_shot on the same channel: acc[ch_sel] ← 0, ovf[ch_sel] ← 0, and no acc_done pulse.
- read loads Data_Output ← acc[ch_sel] and out_ch ← ch_sel, using the pre-update register value. A simultaneous read and accumulate returns the old value.
- Unselected channels never change.

## Timing
- Reset, asynchronous, while n_rst = 0:
  - all acc = 0, ovf = 0, Data_Output = 0, out_ch = 0, acc_done = 0
  - FSM = IDLE, counter = 0, synchronizer = 1
- Press latency: a clean n_enable fall reaches the synced level after 2 edges. one_shot asserts DEBOUNCE_CYCLES-1 edges after entering ARM_PRESS. The accumulator updates at the next edge. acc_done is high for the cycle following the update edge.
- read → Data_Output valid after 1 edge.
- A press held indefinitely yields exactly one one_shot. The next accumulate requires a debounced release and a new debounced press.
- Reset asserted in any FSM state aborts a pending press. After reset release, a full new debounce is required before any pulse.
- ch_sel values ≥ CHANNELS (non-power-of-two CHANNELS) are ignored for accumulate and clear. For read, such values load 0 and out_ch = ch_sel.

## Test plan
Conditions for all scenarios: Word_Length = 8, CHANNELS = 4, DEBOUNCE_CYCLES = 4, SATURATE = 1 unless stated.
- **Single press:** after reset, set ch_sel = 1, Data_Input = 5, sub = 0, hold n_enable low for 20 cycles, then read. Required: exactly one acc_done pulse; Data_Output = 5, out_ch = 1; other channels read 0.
- **Bounce rejection:** n_enable pattern low 2 / high 1 / low 2 / high 10 cycles. Required: no acc_done. Then hold low 10 cycles with Data_Input = 3. Required: exactly one update.
- **Saturate and wrap:** ch0 = 250, add 10. Required: ch0 = 255, ovf[0] = 1. ch1 = 3, subtract 7. Required: ch1 = 0, ovf[1] = 1. Repeat with SATURATE = 0. Required: ch0 = 4, ch1 = 252, both ovf set.
- **Clear vs accumulate and read ordering:** ch2 = 9, ovf[2] = 1. Apply clear, read and one_shot in the same cycle. Required: Data_Output = 9; afterwards ch2 = 0, ovf[2] = 0, and no acc_done pulse.
- **Reset mid-debounce:** assert n_rst low while in ARM_PRESS. Required: all outputs 0 immediately. Keep n_enable low through reset release. Required: no pulse until a debounce completes after release.
- **Hold and re-press:** hold n_enable low for 100 cycles. Required: ch3 increments once. Release for 10 cycles and press again. Required: a second increment.
